// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the stream demultiplexer.
package demux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/demux_dec.sv
// One-hot decode of a channel index, gated by an enable.
// Combinational, no backpressure.
module demux_dec #(
  parameter  int N_CH  = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_CH-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      onehot_o[i] = en_i && (sel_i == SEL_W'(i));
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Single-beat registered demux: routes each input beat to one of N_CH channels.
// Latency 1 cycle; s_ready = !full | m_ready[dest], so drain and accept overlap.
module stream_demux
  import demux_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int N_CH   = 16,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  output logic [N_CH-1:0]   m_valid,
  input  logic [N_CH-1:0]   m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [15:0]       drop_cnt
);

  state_e              state_q;
  logic [DATA_W-1:0]   data_q;
  logic [SEL_W-1:0]    dest_q;
  logic [SEL_W-1:0]    rr_q, rr_d;
  logic [15:0]         drop_q, drop_d;

  logic                full;
  logic                drain;
  logic                accept;
  logic                drop;
  logic [SEL_W-1:0]    dest_new;

  assign full     = (state_q == ST_FULL);
  assign drain    = full && m_ready[dest_q];
  assign s_ready  = !full || m_ready[dest_q];
  assign accept   = s_valid && s_ready;
  assign dest_new = (mode == MODE_RR) ? rr_q : s_sel;
  // Enable is judged only here, at acceptance; a held beat is never revoked.
  assign drop     = accept && !ch_en[dest_new];

  always_comb begin
    rr_d = rr_q;
    if (accept && (mode == MODE_RR)) begin
      rr_d = rr_q + SEL_W'(1);
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      dest_q  <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      drop_q <= drop_d;
      case (state_q)
        ST_EMPTY: begin
          if (accept && !drop) begin
            state_q <= ST_FULL;
            data_q  <= s_data;
            dest_q  <= dest_new;
          end
        end
        ST_FULL: begin
          if (accept && !drop) begin
            data_q <= s_data;
            dest_q <= dest_new;
          end else if (drain) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  demux_dec #(.N_CH(N_CH)) u_dec (
    .en_i     (full),
    .sel_i    (dest_q),
    .onehot_o (m_valid)
  );

  assign m_data   = data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux with default parameters (DATA_W=8, N_CH=16).
module tb_stream_demux;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [15:0] ch_en;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [3:0]  s_sel;
  logic [15:0] m_valid;
  logic [15:0] m_ready;
  logic [7:0]  m_data;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  stream_demux #(.DATA_W(8), .N_CH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .ch_en    (ch_en),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sel    (s_sel),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; mode = 1'b0; ch_en = 16'hFFFF; m_ready = 16'hFFFF;
    s_data = 8'h00; s_sel = 4'd0;
    do_reset();
    checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL reset_m_valid: got %h expected %h", m_valid, 16'h0000); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected %h", m_data, 8'h00); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL reset_drop_cnt: got %h expected %h", drop_cnt, 16'h0000); end
  endtask

  task automatic test_addressed();
    mode = 1'b0; ch_en = 16'hFFFF; m_ready = 16'hFFFF;
    s_valid = 1'b1; s_sel = 4'd5; s_data = 8'hA5;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 16'h0020) begin errors++; $display("FAIL addr_m_valid: got %h expected %h", m_valid, 16'h0020); end
    checks++; if (m_data !== 8'hA5) begin errors++; $display("FAIL addr_m_data: got %h expected %h", m_data, 8'hA5); end
    tick();
    checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL addr_drained: got %h expected %h", m_valid, 16'h0000); end
  endtask

  task automatic test_backpressure();
    mode = 1'b0; ch_en = 16'hFFFF; m_ready = 16'hFFF7;
    s_valid = 1'b1; s_sel = 4'd3; s_data = 8'h3C;
    tick();
    s_valid = 1'b0; s_data = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      checks++; if (m_valid !== 16'h0008) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %h expected %h", i, m_valid, 16'h0008); end
      checks++; if (m_data !== 8'h3C) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, m_data, 8'h3C); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_s_ready[%0d]: got %b expected 0", i, s_ready); end
      if (i < 3) tick();
    end
    m_ready = 16'hFFFF;
    s_valid = 1'b1; s_sel = 4'd9; s_data = 8'h77;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_s_ready: got %b expected 1", s_ready); end
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 16'h0200) begin errors++; $display("FAIL bp_overlap_valid: got %h expected %h", m_valid, 16'h0200); end
    checks++; if (m_data !== 8'h77) begin errors++; $display("FAIL bp_overlap_data: got %h expected %h", m_data, 8'h77); end
    tick();
    checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL bp_final_empty: got %h expected %h", m_valid, 16'h0000); end
  endtask

  task automatic test_back_to_back_rr();
    logic [15:0] exp_v;
    do_reset();
    mode = 1'b1; ch_en = 16'hFFFF; m_ready = 16'hFFFF;
    s_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      s_data = 8'(i);
      tick();
      exp_v = 16'h0001 << (i % 16);
      checks++; if (m_valid !== exp_v) begin errors++; $display("FAIL rr_valid[%0d]: got %h expected %h", i, m_valid, exp_v); end
      checks++; if (m_data !== 8'(i)) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", i, m_data, 8'(i)); end
    end
    s_data = 8'h12;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 16'h0004) begin errors++; $display("FAIL rr_ptr_after_wrap: got %h expected %h", m_valid, 16'h0004); end
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    mode = 1'b0; ch_en = 16'hFF7F; m_ready = 16'hFFFF;
    s_valid = 1'b1; s_sel = 4'd7; s_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL drop_addr_valid[%0d]: got %h expected %h", i, m_valid, 16'h0000); end
    end
    s_valid = 1'b0;
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL drop_addr_cnt: got %0d expected 3", drop_cnt); end
    mode = 1'b1; ch_en = 16'hFFFD;
    s_valid = 1'b1; s_data = 8'hA0;
    tick();
    checks++; if (m_valid !== 16'h0001) begin errors++; $display("FAIL drop_rr_ch0: got %h expected %h", m_valid, 16'h0001); end
    checks++; if (m_data !== 8'hA0) begin errors++; $display("FAIL drop_rr_ch0_data: got %h expected %h", m_data, 8'hA0); end
    s_data = 8'hA1;
    tick();
    checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL drop_rr_ch1: got %h expected %h", m_valid, 16'h0000); end
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL drop_rr_cnt: got %0d expected 4", drop_cnt); end
    s_data = 8'hA2;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 16'h0004) begin errors++; $display("FAIL drop_rr_ch2: got %h expected %h", m_valid, 16'h0004); end
    checks++; if (m_data !== 8'hA2) begin errors++; $display("FAIL drop_rr_ch2_data: got %h expected %h", m_data, 8'hA2); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mode = 1'b0; ch_en = 16'h0000; m_ready = 16'hFFFF;
    s_valid = 1'b1; s_sel = 4'd0; s_data = 8'h01;
    for (int i = 0; i < 65535; i++) tick();
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected %h", drop_cnt, 16'hFFFF); end
    tick();
    tick();
    s_valid = 1'b0;
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected %h", drop_cnt, 16'hFFFF); end
    checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL sat_no_valid: got %h expected %h", m_valid, 16'h0000); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; ch_en = 16'hFFFF; m_ready = 16'h0000;
    s_valid = 1'b1; s_data = 8'h5A;
    tick();
    s_valid = 1'b0;
    tick();
    checks++; if (m_valid !== 16'h0001) begin errors++; $display("FAIL mid_held: got %h expected %h", m_valid, 16'h0001); end
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hC3;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    checks++; if (m_valid !== 16'h0000) begin errors++; $display("FAIL mid_m_valid: got %h expected %h", m_valid, 16'h0000); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL mid_m_data: got %h expected %h", m_data, 8'h00); end
    checks++; if (drop_cnt !== 16'h0000) begin errors++; $display("FAIL mid_drop_cnt: got %h expected %h", drop_cnt, 16'h0000); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready: got %b expected 1", s_ready); end
    m_ready = 16'hFFFF; s_valid = 1'b1; s_data = 8'h11;
    tick();
    s_valid = 1'b0;
    checks++; if (m_valid !== 16'h0001) begin errors++; $display("FAIL mid_rr_ptr_zero: got %h expected %h", m_valid, 16'h0001); end
    checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL mid_rr_data: got %h expected %h", m_data, 8'h11); end
    tick();
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; ch_en = 16'hFFFF; s_valid = 1'b0;
    s_data = 8'h00; s_sel = 4'd0; m_ready = 16'hFFFF;
    test_reset();
    test_addressed();
    test_backpressure();
    test_back_to_back_rr();
    test_drop();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of the data path.
REQ-002 SHALL have parameter N_CH, default 16: number of output channels; power of two, 2..64.
REQ-003 SHALL derive localparam SEL_W = log2(N_CH); this is not overridable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port mode, input, 1 bit: 0 = addressed, 1 = round-robin.
REQ-007 SHALL have port ch_en, input, N_CH bits: per-channel enable mask.
REQ-008 SHALL have port s_valid, input, 1 bit: an input beat is offered.
REQ-009 SHALL have port s_ready, output, 1 bit: the block can accept a beat.
REQ-010 SHALL have port s_data, input, DATA_W bits: input payload.
REQ-011 SHALL have port s_sel, input, SEL_W bits: destination channel, used in addressed mode.
REQ-012 SHALL have port m_valid, output, N_CH bits: one-hot per-channel valid.
REQ-013 SHALL have port m_ready, input, N_CH bits: per-channel ready.
REQ-014 SHALL have port m_data, output, DATA_W bits: payload bus shared by all channels.
REQ-015 SHALL have port drop_cnt, output, 16 bits: count of dropped beats.

Function
REQ-016 SHALL hold one beat in an output register: payload, destination index and a full flag (states EMPTY/FULL).
REQ-017 SHALL accept a beat when s_valid and s_ready are both 1 in the same cycle.
REQ-018 SHALL drive s_ready = !full OR m_ready[dest]; a drain and a new accept in the same cycle are allowed (full throughput).
REQ-019 SHALL drive m_valid[i] = full AND (dest == i); at most one m_valid bit is ever 1.
REQ-020 SHALL drive m_data from the payload register at all times; m_data is don't-care to the sink while EMPTY.
REQ-021 SHALL complete a drain when full AND m_ready[dest] are both 1.
REQ-022 SHALL choose the destination at acceptance time:
  - mode 0: destination = s_sel.
  - mode 1: destination = rr_ptr.
REQ-023 SHALL sample mode on each accepted beat; a beat already held is unaffected by a later mode change.
REQ-024 SHALL advance rr_ptr by 1 on every accepted beat while mode = 1, including dropped beats, wrapping from N_CH-1 to 0.
REQ-025 SHALL hold rr_ptr while mode = 0.
REQ-026 SHALL drop an accepted beat whose destination has ch_en = 0:
  - the beat is consumed without being loaded;
  - drop_cnt increments by 1, saturating at 16'hFFFF;
  - full is set to 0 if a drain also occurs in that cycle, otherwise it is left unchanged.
REQ-027 SHALL accept and drop a beat to a disabled channel while the block is FULL only under the s_ready rule in REQ-018.
REQ-028 SHALL evaluate ch_en at acceptance time only; clearing ch_en does not affect a held beat.
REQ-029 SHALL have a latency of 1 cycle: a beat accepted at edge k is presented on m_valid after edge k.
REQ-030 SHALL give a non-dropped accept the following next-state: full = 1, with the new payload and destination.
REQ-031 SHALL give a drain with no accept the following next-state: full = 0.
REQ-032 SHALL keep m_data and dest stable while full = 1 and no drain occurs.

Reset
REQ-033 SHALL, while rst = 1 at a clock edge, set full = 0, dest = 0, payload = 0, rr_ptr = 0 and drop_cnt = 0.
REQ-034 SHALL, as a consequence of REQ-033, drive m_valid = 0, m_data = 0 and s_ready = 1 after reset.
REQ-035 SHALL discard a held beat when reset is asserted mid-operation; no beat is accepted in a cycle where rst = 1.

Structure
REQ-036 SHALL define the mode constants MODE_ADDR = 0 and MODE_RR = 1 in shared package demux_pkg.
REQ-037 SHALL implement the one-hot SEL_W-to-N_CH decode of dest into m_valid as sub-module demux_dec, parametrised on N_CH.

Verification
REQ-038 SHALL cover addressed routing: mode=0, ch_en=all-1s, s_sel=5, s_data=8'hA5, m_ready=all-1s -> next cycle m_valid=16'h0020, m_data=8'hA5, then m_valid=0.
REQ-039 SHALL cover backpressure: beat to ch 3 with m_ready[3]=0 for 4 cycles -> m_valid[3] held for 4 cycles, m_data stable, s_ready=0; m_ready[3]=1 -> drain, s_ready=1 in the same cycle.
REQ-040 SHALL cover round-robin wrap: mode=1, 18 back-to-back beats, data=0..17 -> channels 0..15, then 0, 1; rr_ptr=2 at the end.
REQ-041 SHALL cover the drop path: ch_en[7]=0, mode=0, s_sel=7, 3 beats -> no m_valid, drop_cnt=3; in RR mode with ch_en[1]=0, beats go to ch 0, ch 1 is dropped, then ch 2.
REQ-042 SHALL cover drop_cnt saturation: preload via 65537 dropped beats -> drop_cnt=16'hFFFF.
REQ-043 SHALL cover reset mid-operation: beat held in FULL with m_ready=0, rst pulsed for 1 cycle -> m_valid=0, m_data=0, rr_ptr=0, drop_cnt=0, s_ready=1.
